// File: rtl/ex_md_stage.sv
// Execute stage: registered single-cycle ALU, multi-cycle multiplier, iterative divider, HI/LO.
// Optional macro EX_OVF_TRAP_EN: signed overflow on ADD/SUB raises ovf_o and suppresses wreg_o.
module ex_md_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MUL_LAT    = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [4:0]            aluop_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  busy_o,
    output logic                  ovf_o
);
    localparam int unsigned SH_W  = $clog2(DATA_W);
    localparam int unsigned CNT_W = $clog2(DATA_W + MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [4:0] OP_ADD  = 5'd1,  OP_ADDU = 5'd2,  OP_SUB  = 5'd3,  OP_SUBU = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_XOR  = 5'd7,  OP_NOR  = 5'd8;
    localparam logic [4:0] OP_SLT  = 5'd9,  OP_SLTU = 5'd10, OP_SLL  = 5'd11, OP_SRL  = 5'd12;
    localparam logic [4:0] OP_SRA  = 5'd13, OP_MULT = 5'd14, OP_MULTU = 5'd15, OP_DIV = 5'd16;
    localparam logic [4:0] OP_DIVU = 5'd17, OP_MFHI = 5'd18, OP_MFLO = 5'd19, OP_MTHI = 5'd20;
    localparam logic [4:0] OP_MTLO = 5'd21, OP_MUL  = 5'd22;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [4:0]              r_op;
    logic [REG_ADDR_W-1:0]   r_md_wd;
    logic                    r_md_wreg;
    logic [2*DATA_W-1:0]     r_prod;
    logic [DATA_W-1:0]       r_rem, r_quo, r_dvs;
    logic                    r_neg_q, r_neg_r;
    logic                    r_valid, r_wreg, r_ovf;
    logic [DATA_W-1:0]       r_wdata, r_hi, r_lo;
    logic [REG_ADDR_W-1:0]   r_wd;

    logic                    w_accept, w_is_mul, w_is_div, w_a_neg, w_b_neg;
    logic [SH_W-1:0]         w_sh;
    logic [DATA_W-1:0]       w_sum, w_diff, w_alu_res;
    logic                    w_add_ovf, w_sub_ovf, w_alu_wreg, w_alu_ovf;
    logic [2*DATA_W-1:0]     w_prod_s, w_prod_u;
    logic [DATA_W:0]         w_shift, w_trial;

    assign ready_o  = (r_state == StIdle) && (!r_valid || ready_i) && !flush_i;
    assign w_accept = valid_i && ready_o;
    assign w_is_mul = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU) || (aluop_i == OP_MUL);
    assign w_is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign w_a_neg  = (aluop_i == OP_DIV) && reg1_i[DATA_W-1];
    assign w_b_neg  = (aluop_i == OP_DIV) && reg2_i[DATA_W-1];
    assign w_sh     = reg1_i[SH_W-1:0];
    assign w_sum    = reg1_i + reg2_i;
    assign w_diff   = reg1_i - reg2_i;
    assign w_prod_s = {{DATA_W{reg1_i[DATA_W-1]}}, reg1_i} * {{DATA_W{reg2_i[DATA_W-1]}}, reg2_i};
    assign w_prod_u = {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};
    // Restoring divider step on magnitudes: shift in next dividend bit, try subtracting.
    assign w_shift  = {r_rem, r_quo[DATA_W-1]};
    assign w_trial  = w_shift - {1'b0, r_dvs};

`ifdef EX_OVF_TRAP_EN
    assign w_add_ovf = (reg1_i[DATA_W-1] == reg2_i[DATA_W-1]) &&
                       (w_sum[DATA_W-1] != reg1_i[DATA_W-1]);
    assign w_sub_ovf = (reg1_i[DATA_W-1] != reg2_i[DATA_W-1]) &&
                       (w_diff[DATA_W-1] != reg1_i[DATA_W-1]);
`else
    assign w_add_ovf = 1'b0;
    assign w_sub_ovf = 1'b0;
`endif

    always_comb begin
        w_alu_res  = '0;
        w_alu_wreg = wreg_i;
        w_alu_ovf  = 1'b0;
        case (aluop_i)
            OP_ADD:  begin w_alu_res = w_sum;  w_alu_ovf = w_add_ovf; end
            OP_ADDU: w_alu_res = w_sum;
            OP_SUB:  begin w_alu_res = w_diff; w_alu_ovf = w_sub_ovf; end
            OP_SUBU: w_alu_res = w_diff;
            OP_AND:  w_alu_res = reg1_i & reg2_i;
            OP_OR:   w_alu_res = reg1_i | reg2_i;
            OP_XOR:  w_alu_res = reg1_i ^ reg2_i;
            OP_NOR:  w_alu_res = ~(reg1_i | reg2_i);
            OP_SLT:  w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
            OP_SLTU: w_alu_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
            OP_SLL:  w_alu_res = reg2_i << w_sh;
            OP_SRL:  w_alu_res = reg2_i >> w_sh;
            OP_SRA:  w_alu_res = $signed(reg2_i) >>> w_sh;
            OP_MFHI: w_alu_res = r_hi;
            OP_MFLO: w_alu_res = r_lo;
            default: w_alu_wreg = 1'b0;
        endcase
        if (w_alu_ovf) begin
            w_alu_wreg = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_op      <= '0;
            r_md_wd   <= '0;
            r_md_wreg <= 1'b0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_valid   <= 1'b0;
            r_wdata   <= '0;
            r_wd      <= '0;
            r_wreg    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_ovf     <= 1'b0;
        end else if (flush_i) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_accept && w_is_mul) begin
                        r_state   <= StMul;
                        r_cnt     <= CNT_W'(MUL_LAT);
                        r_op      <= aluop_i;
                        r_md_wd   <= wd_i;
                        r_md_wreg <= (aluop_i == OP_MUL) && wreg_i;
                        r_prod    <= (aluop_i == OP_MULTU) ? w_prod_u : w_prod_s;
                    end else if (w_accept && w_is_div) begin
                        r_state   <= StDiv;
                        r_cnt     <= CNT_W'(DATA_W);
                        r_md_wd   <= wd_i;
                        r_rem     <= '0;
                        r_quo     <= w_a_neg ? -reg1_i : reg1_i;
                        r_dvs     <= w_b_neg ? -reg2_i : reg2_i;
                        // Divide-by-zero keeps the all-ones quotient regardless of signs.
                        r_neg_q   <= (w_a_neg ^ w_b_neg) && (reg2_i != '0);
                        r_neg_r   <= w_a_neg;
                    end else if (w_accept) begin
                        r_valid <= 1'b1;
                        r_wdata <= w_alu_res;
                        r_wd    <= wd_i;
                        r_wreg  <= w_alu_wreg;
                        r_ovf   <= w_alu_ovf;
                        if (aluop_i == OP_MTHI) r_hi <= reg1_i;
                        if (aluop_i == OP_MTLO) r_lo <= reg1_i;
                    end
                end
                StMul: begin
                    if (r_cnt == CNT_ONE) begin
                        r_state <= StIdle;
                        r_valid <= 1'b1;
                        r_wd    <= r_md_wd;
                        r_wreg  <= r_md_wreg;
                        r_ovf   <= 1'b0;
                        if (r_op == OP_MUL) begin
                            r_wdata <= r_prod[DATA_W-1:0];
                        end else begin
                            r_wdata <= '0;
                            r_hi    <= r_prod[2*DATA_W-1:DATA_W];
                            r_lo    <= r_prod[DATA_W-1:0];
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                StDiv: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_ONE;
                        r_rem <= w_trial[DATA_W] ? w_shift[DATA_W-1:0] : w_trial[DATA_W-1:0];
                        r_quo <= {r_quo[DATA_W-2:0], ~w_trial[DATA_W]};
                    end else begin
                        r_state <= StIdle;
                        r_valid <= 1'b1;
                        r_wdata <= '0;
                        r_wd    <= r_md_wd;
                        r_wreg  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_lo    <= r_neg_q ? -r_quo : r_quo;
                        r_hi    <= r_neg_r ? -r_rem : r_rem;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign valid_o = r_valid;
    assign wdata_o = r_wdata;
    assign wd_o    = r_wd;
    assign wreg_o  = r_wreg;
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;
    assign busy_o  = (r_state != StIdle);
    assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_ex_md_stage.sv
// Scoreboard bench for ex_md_stage: random ops checked against a behavioural model,
// plus directed latency, back-pressure, flush, overflow and reset cases.
module tb_ex_md_stage;
    localparam int unsigned MUL_LAT = 3;

    localparam logic [4:0] OP_ADD  = 5'd1,  OP_ADDU = 5'd2,  OP_SUB  = 5'd3,  OP_SUBU = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_XOR  = 5'd7,  OP_NOR  = 5'd8;
    localparam logic [4:0] OP_SLT  = 5'd9,  OP_SLTU = 5'd10, OP_SLL  = 5'd11, OP_SRL  = 5'd12;
    localparam logic [4:0] OP_SRA  = 5'd13, OP_MULT = 5'd14, OP_MULTU = 5'd15, OP_DIV = 5'd16;
    localparam logic [4:0] OP_DIVU = 5'd17, OP_MFHI = 5'd18, OP_MFLO = 5'd19, OP_MTHI = 5'd20;
    localparam logic [4:0] OP_MTLO = 5'd21, OP_MUL  = 5'd22;

    logic        clk_i = 1'b0;
    logic        rst_i, valid_i, ready_o, flush_i, valid_o, ready_i;
    logic [4:0]  aluop_i, wd_i, wd_o;
    logic [31:0] reg1_i, reg2_i, wdata_o, hi_o, lo_o;
    logic        wreg_i, wreg_o, busy_o, ovf_o;

    ex_md_stage #(.DATA_W(32), .REG_ADDR_W(5), .MUL_LAT(MUL_LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .aluop_i(aluop_i), .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .wdata_o(wdata_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] wdata;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] m_hi, m_lo;
    bit          rand_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Reference model: architectural result of one op, applied in acceptance order.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] wd, input logic wr);
        exp_t        e;
        longint      s;
        logic [63:0] p;
        e = '0;
        e.wd = wd;
        case (op)
            OP_ADD, OP_SUB: begin
                s = (op == OP_ADD) ? longint'($signed(a)) + longint'($signed(b))
                                   : longint'($signed(a)) - longint'($signed(b));
                e.wdata = s[31:0];
                e.wreg  = wr;
`ifdef EX_OVF_TRAP_EN
                if (s != longint'($signed(s[31:0]))) begin
                    e.ovf  = 1'b1;
                    e.wreg = 1'b0;
                end
`endif
            end
            OP_ADDU: begin e.wdata = a + b; e.wreg = wr; end
            OP_SUBU: begin e.wdata = a - b; e.wreg = wr; end
            OP_AND:  begin e.wdata = a & b; e.wreg = wr; end
            OP_OR:   begin e.wdata = a | b; e.wreg = wr; end
            OP_XOR:  begin e.wdata = a ^ b; e.wreg = wr; end
            OP_NOR:  begin e.wdata = ~(a | b); e.wreg = wr; end
            OP_SLT:  begin e.wdata = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.wreg = wr; end
            OP_SLTU: begin e.wdata = (a < b) ? 32'd1 : 32'd0; e.wreg = wr; end
            OP_SLL:  begin e.wdata = b << a[4:0]; e.wreg = wr; end
            OP_SRL:  begin e.wdata = b >> a[4:0]; e.wreg = wr; end
            OP_SRA:  begin e.wdata = $signed(b) >>> a[4:0]; e.wreg = wr; end
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            OP_MUL: begin
                p = longint'($signed(a)) * longint'($signed(b));
                e.wdata = p[31:0];
                e.wreg  = wr;
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a; m_hi = 32'd0;
                end else begin
                    m_lo = $signed(a) / $signed(b);
                    m_hi = $signed(a) % $signed(b);
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            OP_MFHI: begin e.wdata = m_hi; e.wreg = wr; end
            OP_MFLO: begin e.wdata = m_lo; e.wreg = wr; end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        return e;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic wr, input bit push, output int waits);
        valid_i = 1'b1; aluop_i = op; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr;
        waits = 0;
        do begin
            @(negedge clk_i);
            waits++;
        end while (!ready_o && waits < 200);
        if (!ready_o) begin
            valid_i = 1'b0;
            n_checks++;
            $display("FAIL accept_timeout: op %0d waited %0d cycles, want acceptance", op, waits);
        end else if (push) begin
            sb_q.push_back(model(op, a, b, wd, wr));
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(posedge clk_i); #1;
            t++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy_o && n < 100) begin
            check("ready_low_while_busy", ready_o, 0);
            n++;
            @(posedge clk_i); #1;
        end
    endtask

    // Monitor: one comparison set per result transfer.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: wdata %h, want no result", wdata_o);
            end else begin
                mon_e = sb_q.pop_front();
                check("wdata", wdata_o, mon_e.wdata);
                check("wd", wd_o, mon_e.wd);
                check("wreg", wreg_o, mon_e.wreg);
                check("hi", hi_o, mon_e.hi);
                check("lo", lo_o, mon_e.lo);
                check("ovf", ovf_o, mon_e.ovf);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_i); #1;
            if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, waits;
        exp_t he;
        rst_i = 1'b1; valid_i = 1'b0; aluop_i = '0; reg1_i = '0; reg2_i = '0; wd_i = '0;
        wreg_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1; rand_ready = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_wd", wd_o, 0);
        check("rst_wreg", wreg_o, 0);
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ovf", ovf_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        issue(OP_ADDU, 32'hFFFF_FFFF, 32'h1, 5'd3, 1'b1, 1'b1, waits);
        check("addu_latency1_valid", valid_o, 1);
        check("addu_wdata_const", wdata_o, 32'h0);
        drain();

        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b1, 1'b1, waits);
        count_busy(n);
        check("mult_busy_cycles", n, MUL_LAT);
        check("mult_valid_after", valid_o, 1);
        check("mult_hi_const", hi_o, 32'hFFFF_FFFF);
        check("mult_lo_const", lo_o, 32'hFFFF_FFFA);
        drain();
        issue(OP_MFLO, 32'd0, 32'd0, 5'd8, 1'b1, 1'b1, waits);
        check("mflo_const", wdata_o, 32'hFFFF_FFFA);
        drain();

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0, 1'b1, waits);
        count_busy(n);
        check("div_busy_cycles", n, 33);
        check("div_lo_const", lo_o, 32'hFFFF_FFFD);
        check("div_hi_const", hi_o, 32'hFFFF_FFFF);
        drain();
        issue(OP_DIVU, 32'd5, 32'd0, 5'd0, 1'b0, 1'b1, waits);
        count_busy(n);
        check("divu0_lo_const", lo_o, 32'hFFFF_FFFF);
        check("divu0_hi_const", hi_o, 32'd5);
        drain();

        // Back-pressure: result must hold while ready_i is low.
        ready_i = 1'b0;
        issue(OP_OR, 32'h1234_0000, 32'h0000_5678, 5'd7, 1'b1, 1'b1, waits);
        he = sb_q[sb_q.size()-1];
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", valid_o, 1);
            check("hold_wdata", wdata_o, he.wdata);
            check("hold_wd", wd_o, he.wd);
            check("hold_ready_low", ready_o, 0);
            @(posedge clk_i); #1;
        end
        ready_i = 1'b1;
        drain();

        // Flush in the tenth divider cycle.
        issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd0, 1'b0, 1'b0, waits);
        repeat (9) begin @(posedge clk_i); #1; end
        flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_ready_low", ready_o, 0);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("flush_busy", busy_o, 0);
        check("flush_valid", valid_o, 0);
        check("flush_hi", hi_o, m_hi);
        check("flush_lo", lo_o, m_lo);
        issue(OP_ADDU, 32'd10, 32'd20, 5'd9, 1'b1, 1'b1, waits);
        check("flush_next_accept_wait", waits, 1);
        drain();

        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd4, 1'b1, 1'b1, waits);
`ifdef EX_OVF_TRAP_EN
        check("ovf_flag_const", ovf_o, 1);
        check("ovf_wreg_const", wreg_o, 0);
`else
        check("add_wdata_const", wdata_o, 32'h8000_0000);
        check("add_wreg_const", wreg_o, 1);
        check("add_ovf_const", ovf_o, 0);
`endif
        drain();

        rand_ready = 1'b1;
        for (int k = 0; k < 250; k++) begin
            issue(5'($urandom_range(0, 31)), rnd_operand(), rnd_operand(),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1, waits);
        end
        rand_ready = 1'b0;
        ready_i = 1'b1;
        drain();

        // Asynchronous reset in the middle of a multiply.
        issue(OP_MULT, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0, waits);
        #2 rst_i = 1'b1;
        #1;
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_valid", valid_o, 0);
        check("rst_mid_hi", hi_o, 0);
        check("rst_mid_lo", lo_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
